// File: rtl/ram_march_tester.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_tester
//  Description : March C- test controller for a write-strobe-clocked RAM.
//                Drives wr/din/addr, checks the combinational read data and
//                reports pass/fail plus the first failing location.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_march_tester #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 2,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [WIDTH-1:0]  fail_data,
  output logic              mem_wr,
  output logic [WIDTH-1:0]  mem_din,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_STROBE = 3'd2,
    S_R_ADDR   = 3'd3,
    S_R_CHECK  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  localparam logic [AWIDTH-1:0] c_addr_last = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] c_addr_one  = AWIDTH'(1);
  localparam logic [2:0]        c_elem_last = 3'd5;
  localparam logic [WIDTH-1:0]  c_d0        = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  c_d1        = {WIDTH{1'b1}};

  // Elements 3 and 4 walk the address space downwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Elements 1..4 are read-then-write; 0 is write-only and 5 read-only.
  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e != 3'd0) && (e != c_elem_last);
  endfunction

  // Background expected on reads: D1 in elements 2 and 4, else D0.
  function automatic logic [WIDTH-1:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? c_d1 : c_d0;
  endfunction

  // Background written: D1 in elements 1 and 3, else D0.
  function automatic logic [WIDTH-1:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? c_d1 : c_d0;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_wr_q, mem_wr_d;
  logic              pass_q, pass_d;
  logic [AWIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [WIDTH-1:0]  fail_data_q, fail_data_d;

  logic              op_done;
  logic              last_addr;

  // Next-state, counter sequencing and registered-output decode.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    op_d        = op_q;
    din_d       = din_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    op_done     = 1'b0;
    last_addr   = elem_down(elem_q) ? (addr_q == '0) : (addr_q == c_addr_last);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_W_SETUP;
          elem_d      = 3'd0;
          addr_d      = '0;
          op_d        = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          fail_data_d = '0;
        end
      end
      S_W_SETUP:  state_d = S_W_STROBE;
      S_W_STROBE: op_done = 1'b1;
      S_R_ADDR:   state_d = S_R_CHECK;
      S_R_CHECK: begin
        if (mem_dout != rd_bg(elem_q)) begin
          // First mismatch: latch the location and stop without more writes.
          state_d     = S_FINISH;
          fail_addr_d = addr_q;
          fail_elem_d = elem_q;
          fail_data_d = mem_dout;
        end else begin
          op_done = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (op_done) begin
      if (elem_two_ops(elem_q) && !op_q) begin
        // Second op of a read/write element is always the write.
        op_d    = 1'b1;
        state_d = S_W_SETUP;
      end else begin
        op_d = 1'b0;
        if (last_addr) begin
          if (elem_q == c_elem_last) begin
            state_d = S_FINISH;
            pass_d  = 1'b1;
          end else begin
            // Every element after e0 opens with a read.
            elem_d  = elem_q + 3'd1;
            addr_d  = elem_down(elem_d) ? c_addr_last : '0;
            state_d = S_R_ADDR;
          end
        end else begin
          addr_d  = elem_down(elem_q) ? (addr_q - c_addr_one) : (addr_q + c_addr_one);
          state_d = (elem_q == 3'd0) ? S_W_SETUP : S_R_ADDR;
        end
      end
    end

    if (state_d == S_W_SETUP) begin
      din_d = wr_bg(elem_d);
    end

    busy_d   = (state_d == S_W_SETUP) || (state_d == S_W_STROBE) ||
               (state_d == S_R_ADDR)  || (state_d == S_R_CHECK);
    done_d   = (state_d == S_FINISH);
    mem_wr_d = (state_d == S_W_STROBE);
  end

  // State, counters, result and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_wr_q    <= mem_wr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;
  assign mem_wr    = mem_wr_q;
  assign mem_din   = din_q;
  assign mem_addr  = addr_q;

endmodule
`default_nettype wire
